// File: rtl/mux157_arb_pkg.sv
// Shared types and constants for the hct74157 mux arbiter.
// The state encoding is fixed so that external checkers can decode it.
package mux157_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    SETTLE = 2'd2,
    GRANT  = 2'd3
  } arb_state_t;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

endpackage

// File: rtl/mux157_settle_counter.sv
// Loadable down-counter that times the mux settle window.
// zero is decoded from the register, so it is valid in the cycle after a load.
module mux157_settle_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mux157_arbiter.sv
// Break-before-make arbiter sharing one hct74157 quad 2:1 mux between two requesters.
// Every output is registered; S only moves while _E is high.
module mux157_arbiter
  import mux157_arb_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_HOLD      = 8,
  parameter int HOLD_W        = 4
) (
  input  logic       clk,
  input  logic       _reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       S,
  output logic       _E,
  output logic       busy
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  arb_state_t        state_q, state_d;
  logic              win_q, win_d;
  logic              last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              s_q, s_d;
  logic              e_n_q, e_n_d;
  logic              busy_q, busy_d;
  logic              settle_load;
  logic              settle_en;
  logic              settle_zero;
  logic              preempt;

  mux157_settle_counter #(
    .W (SW)
  ) u_settle (
    .clk      (clk),
    .rst_n    (_reset),
    .load     (settle_load),
    .load_val (SW'(SETTLE_CYCLES - 1)),
    .en       (settle_en),
    .zero     (settle_zero)
  );

  // Preemption only when a limit is configured and the other side is waiting.
  assign preempt = (MAX_HOLD != 0) && req[~win_q] &&
                   (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    last_d      = last_q;
    hold_d      = hold_q;
    gnt_d       = 2'b00;
    s_d         = s_q;
    e_n_d       = 1'b1;
    settle_load = 1'b0;
    settle_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          win_d   = (req == 2'b11) ? ~last_q : req[REQ1];
          s_d     = win_d;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (req[win_q]) begin
          state_d     = SETTLE;
          settle_load = 1'b1;
          e_n_d       = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (!req[win_q]) begin
          state_d = IDLE;
        end else if (settle_zero) begin
          state_d       = GRANT;
          e_n_d         = 1'b0;
          gnt_d[win_q]  = 1'b1;
        end else begin
          settle_en = 1'b1;
          e_n_d     = 1'b0;
        end
      end
      GRANT: begin
        if (hold_q != {HOLD_W{1'b1}}) begin
          hold_d = hold_q + 1'b1;
        end
        if (!req[win_q] || preempt) begin
          state_d = IDLE;
          last_d  = win_q;
          hold_d  = '0;
        end else begin
          e_n_d        = 1'b0;
          gnt_d[win_q] = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      hold_q  <= '0;
      gnt_q   <= 2'b00;
      s_q     <= 1'b0;
      e_n_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      e_n_q   <= e_n_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign S    = s_q;
  assign _E   = e_n_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mux157_arbiter.sv
// Directed bench for mux157_arbiter with a behavioural hct74157 on the shared bus.
module tb_mux157_arbiter;

  logic       clk;
  logic       _reset;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       s;
  logic       e_n;
  logic       busy;
  logic [1:0] req_nl;
  logic [1:0] gnt_nl;
  logic       s_nl;
  logic       e_n_nl;
  logic       busy_nl;
  logic [3:0] y;

  localparam logic [3:0] I0 = 4'b1010;
  localparam logic [3:0] I1 = 4'b0101;

  int checks;
  int errors;

  mux157_arbiter #(.SETTLE_CYCLES(2), .MAX_HOLD(8), .HOLD_W(4)) u_dut (
    .clk    (clk),
    ._reset (_reset),
    .req    (req),
    .gnt    (gnt),
    .S      (s),
    ._E     (e_n),
    .busy   (busy)
  );

  mux157_arbiter #(.SETTLE_CYCLES(2), .MAX_HOLD(0), .HOLD_W(4)) u_nolim (
    .clk    (clk),
    ._reset (_reset),
    .req    (req_nl),
    .gnt    (gnt_nl),
    .S      (s_nl),
    ._E     (e_n_nl),
    .busy   (busy_nl)
  );

  // hct74157: outputs forced low while _E is high.
  assign y = e_n ? 4'b0000 : (s ? I1 : I0);

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    _reset = 1'b0;
    req    = 2'b00;
    req_nl = 2'b00;
    #2;
    _reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    _reset = 1'b1;
    req    = 2'b00;
    req_nl = 2'b00;

    // 1: asynchronous reset, before the first clock edge
    #1;
    _reset = 1'b0;
    req    = 2'b11;
    req_nl = 2'b11;
    #1;
    check("rst_gnt",  {6'd0, gnt}, 8'h00);
    check("rst_e",    {7'd0, e_n}, 8'h01);
    check("rst_s",    {7'd0, s},   8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    tick();
    check("rst_hold_gnt", {6'd0, gnt}, 8'h00);
    req    = 2'b00;
    req_nl = 2'b00;
    _reset = 1'b1;
    tick();

    // 2: single request on I0
    req = 2'b01;
    tick();
    check("t2_e1_s",    {7'd0, s},    8'h00);
    check("t2_e1_e",    {7'd0, e_n},  8'h01);
    check("t2_e1_busy", {7'd0, busy}, 8'h01);
    tick();
    check("t2_e2_e",   {7'd0, e_n}, 8'h00);
    check("t2_e2_gnt", {6'd0, gnt}, 8'h00);
    tick();
    check("t2_e3_gnt", {6'd0, gnt}, 8'h00);
    tick();
    check("t2_e4_gnt", {6'd0, gnt}, 8'h01);
    check("t2_e4_y",   {4'd0, y},   8'h0a);
    req = 2'b00;
    tick();
    check("t2_end_gnt",  {6'd0, gnt},  8'h00);
    check("t2_end_e",    {7'd0, e_n},  8'h01);
    check("t2_end_busy", {7'd0, busy}, 8'h00);

    // 3/4: both requesting from reset; requester 0 first, preempted after 8 cycles
    apply_reset();
    req    = 2'b11;
    req_nl = 2'b11;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("t3_pre_gnt", {6'd0, gnt}, 8'h00);
    end
    tick();
    check("t3_e4_gnt",    {6'd0, gnt},    8'h01);
    check("t4_nl_e4_gnt", {6'd0, gnt_nl}, 8'h01);
    for (int e = 5; e <= 11; e++) begin
      tick();
      check("t4_hold_gnt", {6'd0, gnt},    8'h01);
      check("t4_nl_gnt",   {6'd0, gnt_nl}, 8'h01);
    end
    tick();
    check("t4_e12_gnt",  {6'd0, gnt},  8'h00);
    check("t4_e12_e",    {7'd0, e_n},  8'h01);
    check("t4_e12_s",    {7'd0, s},    8'h00);
    check("t4_e12_busy", {7'd0, busy}, 8'h00);
    tick();
    check("t3_e13_s",   {7'd0, s},   8'h01);
    check("t3_e13_e",   {7'd0, e_n}, 8'h01);
    check("t3_e13_gnt", {6'd0, gnt}, 8'h00);
    tick();
    check("t3_e14_e", {7'd0, e_n}, 8'h00);
    check("t3_e14_s", {7'd0, s},   8'h01);
    tick();
    check("t3_e15_gnt", {6'd0, gnt}, 8'h00);
    tick();
    check("t3_e16_gnt",   {6'd0, gnt},    8'h10 >> 3);
    check("t3_e16_y",     {4'd0, y},      8'h05);
    check("t4_nl_e16_gnt", {6'd0, gnt_nl}, 8'h01);
    for (int e = 17; e <= 30; e++) begin
      tick();
      check("t4_nl_long_gnt", {6'd0, gnt_nl}, 8'h01);
    end
    req    = 2'b00;
    req_nl = 2'b00;
    tick();
    check("t3_end_gnt", {6'd0, gnt}, 8'h00);

    // 5: abort during SETTLE leaves last untouched
    apply_reset();
    req = 2'b01;
    tick();
    tick();
    check("t5_settle_e", {7'd0, e_n}, 8'h00);
    req = 2'b00;
    tick();
    check("t5_abort_e",    {7'd0, e_n},  8'h01);
    check("t5_abort_busy", {7'd0, busy}, 8'h00);
    check("t5_abort_gnt",  {6'd0, gnt},  8'h00);
    tick();
    check("t5_idle_gnt", {6'd0, gnt}, 8'h00);
    req = 2'b11;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("t5_pre_gnt", {6'd0, gnt}, 8'h00);
    end
    tick();
    check("t5_e4_gnt", {6'd0, gnt}, 8'h01);

    // 6: asynchronous reset while in GRANT
    #2;
    _reset = 1'b0;
    #1;
    check("t6_rst_gnt",  {6'd0, gnt},  8'h00);
    check("t6_rst_e",    {7'd0, e_n},  8'h01);
    check("t6_rst_busy", {7'd0, busy}, 8'h00);
    req = 2'b00;
    #1;
    _reset = 1'b1;
    tick();
    req = 2'b10;
    tick();
    check("t6_e1_s", {7'd0, s}, 8'h01);
    tick();
    tick();
    check("t6_e3_gnt", {6'd0, gnt}, 8'h00);
    tick();
    check("t6_e4_gnt", {6'd0, gnt}, 8'h02);
    check("t6_e4_y",   {4'd0, y},   8'h05);
    req = 2'b00;
    tick();
    check("t6_end_gnt", {6'd0, gnt}, 8'h00);
    check("t6_end_e",   {7'd0, e_n}, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
